// File: rtl/mem_bus_arbiter.sv
// Shares one external memory port between I-cache refills and D-cache refills/writebacks.
// Optional macro MEMARB_RR_EN: round-robin tie-break instead of fixed D-over-I priority.
module mem_bus_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_abort,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rvalid,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_wready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam int OFF_W = CNT_W + 2;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((1 << OFF_W) - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_IBURST = 2'd1;
  localparam logic [1:0] S_DBURST = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;   // 1 = D side
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              we_q, we_d;
  logic              squash_q, squash_d;

  logic in_burst, beat_fire, i_elig, pick_d;
  logic i_rd, d_rd, d_wr;

  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
    return a & ~OFF_MASK;
  endfunction

  assign in_burst  = (state_q == S_IBURST) || (state_q == S_DBURST);
  assign beat_fire = in_burst && mem_ack;
  assign i_elig    = i_req && !i_abort;

`ifdef MEMARB_RR_EN
  logic last_q, last_d;   // 1 = D owned the previous grant
  assign pick_d = d_req && (!i_elig || !last_q);
`else
  assign pick_d = d_req;
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    beat_d   = beat_q;
    base_d   = base_q;
    we_d     = we_q;
    squash_d = squash_q;
`ifdef MEMARB_RR_EN
    last_d   = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pick_d) begin
          state_d = S_DBURST;
          owner_d = 1'b1;
          base_d  = line_base(d_addr);
          we_d    = d_we;
          beat_d  = '0;
`ifdef MEMARB_RR_EN
          last_d  = 1'b1;
`endif
        end else if (i_elig) begin
          state_d = S_IBURST;
          owner_d = 1'b0;
          base_d  = line_base(i_addr);
          we_d    = 1'b0;
          beat_d  = '0;
`ifdef MEMARB_RR_EN
          last_d  = 1'b0;
`endif
        end
      end
      S_IBURST, S_DBURST: begin
        // A flush cannot cancel the memory burst; it only hides the results.
        if (state_q == S_IBURST && i_abort) squash_d = 1'b1;
        if (beat_fire) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = S_DONE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        squash_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      beat_q   <= '0;
      base_q   <= '0;
      we_q     <= 1'b0;
      squash_q <= 1'b0;
`ifdef MEMARB_RR_EN
      last_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      beat_q   <= beat_d;
      base_q   <= base_d;
      we_q     <= we_d;
      squash_q <= squash_d;
`ifdef MEMARB_RR_EN
      last_q   <= last_d;
`endif
    end
  end

  assign i_rd = (state_q == S_IBURST);
  assign d_rd = (state_q == S_DBURST) && !we_q;
  assign d_wr = (state_q == S_DBURST) && we_q;

  assign mem_req   = in_burst;
  assign mem_we    = d_wr;
  assign mem_addr  = base_q + (ADDR_W'(beat_q) << 2);
  assign mem_wdata = d_wr ? d_wdata : '0;

  // An abort seen in the same cycle as a beat already hides that beat.
  assign i_rvalid = i_rd && mem_ack && !(squash_q || i_abort);
  assign i_rdata  = i_rd ? mem_rdata : '0;
  assign d_rvalid = d_rd && mem_ack;
  assign d_rdata  = d_rd ? mem_rdata : '0;
  assign d_wready = d_wr && mem_ack;

  assign i_done = (state_q == S_DONE) && !owner_q && !squash_q;
  assign d_done = (state_q == S_DONE) && owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: reference model plus directed scenarios.
module tb_mem_bus_arbiter;
  localparam int LW = 4;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef MEMARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          Clk = 1'b0;
  logic          Rst = 1'b0;
  logic          i_req = 1'b0, i_abort = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ack = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, mem_rdata = '0;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          i_rvalid, i_done, d_wready, d_rvalid, d_done, mem_req, mem_we;

  always #5 Clk = ~Clk;

  mem_bus_arbiter #(.LINE_WORDS(LW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .Clk(Clk), .Rst(Rst),
    .i_req(i_req), .i_addr(i_addr), .i_abort(i_abort), .i_rdata(i_rdata),
    .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wready(d_wready), .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_done(d_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: phase 0 idle, 1 burst, 2 done; own 0 = I, 1 = D.
  int            m_phase = 0, m_own = 0, m_k = 0, m_last = 0;
  logic [AW-1:0] m_base = '0;
  bit            m_we = 0, m_sq = 0, m_ie, m_td;

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      m_phase = 0; m_own = 0; m_k = 0; m_last = 0; m_base = '0; m_we = 0; m_sq = 0;
    end else begin
      case (m_phase)
        0: begin
          m_ie = i_req && !i_abort;
          m_td = d_req && (!RR || !m_ie || m_last == 0);
          if (m_td) begin
            m_phase = 1; m_own = 1; m_k = 0; m_we = d_we; m_last = 1;
            m_base = d_addr - (d_addr % (LW * 4));
          end else if (m_ie) begin
            m_phase = 1; m_own = 0; m_k = 0; m_we = 0; m_last = 0;
            m_base = i_addr - (i_addr % (LW * 4));
          end
        end
        1: begin
          if (m_own == 0 && i_abort) m_sq = 1;
          if (mem_ack) begin
            if (m_k == LW - 1) begin m_phase = 2; m_k = 0; end
            else m_k++;
          end
        end
        default: begin m_phase = 0; m_sq = 0; end
      endcase
    end
  end

  int cyc = 0, last_ack_cyc = 0, idone_cyc = 0;
  int n_req = 0, n_beats = 0, n_irv = 0, n_idone = 0, n_ddone = 0, n_dwr = 0, n_drv = 0, n_we = 0;
  logic [AW-1:0] alog[$];
  int            dlog[$];
  bit            e_req, e_we, e_irv, e_drv, e_dwr, e_idone, e_ddone;
  logic [AW-1:0] e_addr;

  always @(negedge Clk) begin
    cyc++;
    e_req   = (m_phase == 1);
    e_we    = e_req && m_own == 1 && m_we;
    e_irv   = e_req && m_own == 0 && mem_ack && !(m_sq || i_abort);
    e_drv   = e_req && m_own == 1 && !m_we && mem_ack;
    e_dwr   = e_req && m_own == 1 && m_we && mem_ack;
    e_idone = (m_phase == 2) && m_own == 0 && !m_sq;
    e_ddone = (m_phase == 2) && m_own == 1;
    e_addr  = m_base + 4 * m_k;
    chk("mem_req", mem_req, e_req);
    chk("mem_we", mem_we, e_we);
    chk("i_rvalid", i_rvalid, e_irv);
    chk("d_rvalid", d_rvalid, e_drv);
    chk("d_wready", d_wready, e_dwr);
    chk("i_done", i_done, e_idone);
    chk("d_done", d_done, e_ddone);
    if (e_req) chk("mem_addr", mem_addr, e_addr);
    if (e_we)  chk("mem_wdata", mem_wdata, d_wdata);
    if (e_irv) chk("i_rdata", i_rdata, mem_rdata);
    if (e_drv) chk("d_rdata", d_rdata, mem_rdata);
    if (mem_req) n_req++;
    if (mem_req && mem_we) n_we++;
    if (mem_req && mem_ack) begin alog.push_back(mem_addr); n_beats++; last_ack_cyc = cyc; end
    if (i_rvalid) n_irv++;
    if (d_rvalid) n_drv++;
    if (d_wready) n_dwr++;
    if (i_done) begin n_idone++; idone_cyc = cyc; dlog.push_back(0); end
    if (d_done) begin n_ddone++; dlog.push_back(1); end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
    mem_rdata = $urandom;
    d_wdata   = $urandom;
  endtask

  task automatic wait_done(input bit d_side, input int budget, input string nm);
    int st;
    bit seen;
    st = d_side ? n_ddone : n_idone;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if ((d_side ? n_ddone : n_idone) > st) seen = 1;
    end
    if (!seen) chk({nm, "_timeout"}, 0, 1);
  endtask

  logic [AW-1:0] exp_i[4] = '{32'h1030, 32'h1034, 32'h1038, 32'h103C};
  logic [AW-1:0] exp_d[4] = '{32'h2000, 32'h2004, 32'h2008, 32'h200C};
  int s_req, s_beats, s_irv, s_idone, s_ddone, s_dwr, s_drv, s_we, s_al, s_dl;
  bit hit;

  task automatic snap();
    s_req = n_req; s_beats = n_beats; s_irv = n_irv; s_idone = n_idone; s_ddone = n_ddone;
    s_dwr = n_dwr; s_drv = n_drv; s_we = n_we; s_al = alog.size(); s_dl = dlog.size();
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_valids", {i_rvalid, d_rvalid, d_wready, i_done, d_done}, 0);
    tick(); tick();
    Rst = 1'b1;
    tick();

    // I refill, ack every cycle
    snap();
    i_addr = 32'h0000_1034; i_req = 1; mem_ack = 1;
    wait_done(0, 30, "irefill");
    i_req = 0; mem_ack = 0;
    chk("irefill_req_cycles", n_req - s_req, 4);
    chk("irefill_rvalid", n_irv - s_irv, 4);
    chk("irefill_done", n_idone - s_idone, 1);
    chk("irefill_done_timing", idone_cyc, last_ack_cyc + 1);
    for (int k = 0; k < 4; k++) chk("irefill_addr", alog[s_al + k], exp_i[k]);
    tick(); tick();

    // D writeback, ack on alternate cycles
    snap();
    d_addr = 32'h2000; d_we = 1; d_req = 1;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      mem_ack = ~mem_ack;
      tick();
      if (n_ddone > s_ddone) hit = 1;
    end
    if (!hit) chk("dwb_timeout", 0, 1);
    d_req = 0; d_we = 0; mem_ack = 0;
    chk("dwb_wready", n_dwr - s_dwr, 4);
    chk("dwb_no_rvalid", n_drv - s_drv, 0);
    chk("dwb_done", n_ddone - s_ddone, 1);
    chk("dwb_we_throughout", n_we - s_we, n_req - s_req);
    for (int k = 0; k < 4; k++) chk("dwb_addr", alog[s_al + k], exp_d[k]);
    tick(); tick();

    // Simultaneous requests, twice in a row
    snap();
    i_addr = 32'h3000; d_addr = 32'h4000; d_we = 0;
    i_req = 1; d_req = 1; mem_ack = 1;
    for (int i = 0; i < 60 && dlog.size() < s_dl + 2; i++) tick();
    i_req = 0; d_req = 0;
    if (dlog.size() < s_dl + 2) chk("tie_timeout", dlog.size(), s_dl + 2);
    else begin
      chk("tie_first_owner", dlog[s_dl], 1);
      chk("tie_second_owner", dlog[s_dl + 1], RR ? 0 : 1);
    end
    repeat (4) tick();
    mem_ack = 0;
    tick();

    // Flush during I refill, abort while beat 2 is presented
    snap();
    i_addr = 32'h5008; i_req = 1; mem_ack = 1;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      tick();
      if (mem_req && mem_addr == 32'h5008) begin
        hit = 1;
        i_abort = 1; i_req = 0;
        tick();
        i_abort = 0;
      end
    end
    if (!hit) chk("flush_reach", 0, 1);
    repeat (8) tick();
    mem_ack = 0;
    chk("flush_beats_issued", n_beats - s_beats, 4);
    chk("flush_rvalid", n_irv - s_irv, 2);
    chk("flush_no_done", n_idone - s_idone, 0);
    snap();
    i_addr = 32'h6000; i_req = 1; mem_ack = 1;
    wait_done(0, 30, "after_flush");
    i_req = 0; mem_ack = 0;
    chk("after_flush_rvalid", n_irv - s_irv, 4);
    chk("after_flush_addr0", alog[s_al], 32'h6000);
    tick(); tick();

    // Reset mid-burst
    i_addr = 32'h7000; i_req = 1; mem_ack = 1;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      tick();
      if (mem_req && mem_addr == 32'h7008) hit = 1;
    end
    if (!hit) chk("rstmid_reach", 0, 1);
    Rst = 0;
    #1;
    chk("rstmid_mem_req", mem_req, 0);
    chk("rstmid_mem_addr", mem_addr, 0);
    chk("rstmid_outs", {mem_we, i_rvalid, i_done, d_wready, d_done}, 0);
    tick();
    Rst = 1;
    tick();
    chk("rstmid_restart_req", mem_req, 1);
    chk("rstmid_restart_addr", mem_addr, 32'h7000);
    wait_done(0, 30, "rstmid");
    i_req = 0; mem_ack = 0;
    tick(); tick();

    // Stalled memory
    d_addr = 32'h801C; d_we = 0; d_req = 1; mem_ack = 0;
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      tick();
      if (mem_req) hit = 1;
    end
    if (!hit) chk("stall_reach", 0, 1);
    snap();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_req", mem_req, 1);
      chk("stall_addr", mem_addr, 32'h8010);
    end
    chk("stall_no_valid", n_drv - s_drv, 0);
    mem_ack = 1;
    wait_done(1, 20, "stall");
    d_req = 0; mem_ack = 0;
    chk("stall_rvalid", n_drv - s_drv, 4);
    chk("stall_addr0", alog[s_al], 32'h8010);
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
